// File: rtl/wb_rr_arb4.sv
// wb_rr_arb4: four-master round-robin Wishbone arbiter with a bus watchdog.
//
// Shares one Wishbone slave port between four bus masters. The grant is
// registered in IDLE and held for the granted master's whole cycle (cyc),
// so bursts need no special treatment. Priority rotates starting after the
// last granted master, so no requester starves. A watchdog aborts a transfer
// with err when the slave leaves a strobe unterminated for TIMEOUT cycles.
//
// Ports:
//   clk, rstn            clock, asynchronous active-low reset
//   mN_*_i / mN_*_o      master N request inputs / read data + terminations
//   s_*_o / s_*_i        muxed request to slave / slave data + terminations
//   gnt_o                one-hot registered grant (0 when idle)
//   timeout_o            one-cycle pulse on watchdog abort
//   dbg_state_o          current arbiter state (IDLE=0, GRANT=1, ABORT=2)
//
// Handshake: a master's request is valid while cyc&stb is high; it completes
// on the cycle ack, err or rty is high. Request and termination paths are
// purely combinational through the registered grant.
module wb_rr_arb4 #(
  parameter int c_DATA_WIDTH = 64,
  parameter int TIMEOUT      = 255
) (
  input  logic                      clk,
  input  logic                      rstn,
  // master 0
  input  logic [c_DATA_WIDTH-1:0]   m0_dat_i,
  output logic [c_DATA_WIDTH-1:0]   m0_dat_o,
  input  logic [31:0]               m0_adr_i,
  input  logic [c_DATA_WIDTH/8-1:0] m0_sel_i,
  input  logic [2:0]                m0_cti_i,
  input  logic                      m0_we_i,
  input  logic                      m0_cyc_i,
  input  logic                      m0_stb_i,
  output logic                      m0_ack_o,
  output logic                      m0_err_o,
  output logic                      m0_rty_o,
  // master 1
  input  logic [c_DATA_WIDTH-1:0]   m1_dat_i,
  output logic [c_DATA_WIDTH-1:0]   m1_dat_o,
  input  logic [31:0]               m1_adr_i,
  input  logic [c_DATA_WIDTH/8-1:0] m1_sel_i,
  input  logic [2:0]                m1_cti_i,
  input  logic                      m1_we_i,
  input  logic                      m1_cyc_i,
  input  logic                      m1_stb_i,
  output logic                      m1_ack_o,
  output logic                      m1_err_o,
  output logic                      m1_rty_o,
  // master 2
  input  logic [c_DATA_WIDTH-1:0]   m2_dat_i,
  output logic [c_DATA_WIDTH-1:0]   m2_dat_o,
  input  logic [31:0]               m2_adr_i,
  input  logic [c_DATA_WIDTH/8-1:0] m2_sel_i,
  input  logic [2:0]                m2_cti_i,
  input  logic                      m2_we_i,
  input  logic                      m2_cyc_i,
  input  logic                      m2_stb_i,
  output logic                      m2_ack_o,
  output logic                      m2_err_o,
  output logic                      m2_rty_o,
  // master 3
  input  logic [c_DATA_WIDTH-1:0]   m3_dat_i,
  output logic [c_DATA_WIDTH-1:0]   m3_dat_o,
  input  logic [31:0]               m3_adr_i,
  input  logic [c_DATA_WIDTH/8-1:0] m3_sel_i,
  input  logic [2:0]                m3_cti_i,
  input  logic                      m3_we_i,
  input  logic                      m3_cyc_i,
  input  logic                      m3_stb_i,
  output logic                      m3_ack_o,
  output logic                      m3_err_o,
  output logic                      m3_rty_o,
  // slave
  output logic [c_DATA_WIDTH-1:0]   s_dat_o,
  output logic [31:0]               s_adr_o,
  output logic [c_DATA_WIDTH/8-1:0] s_sel_o,
  output logic [2:0]                s_cti_o,
  output logic                      s_we_o,
  output logic                      s_cyc_o,
  output logic                      s_stb_o,
  input  logic [c_DATA_WIDTH-1:0]   s_dat_i,
  input  logic                      s_ack_i,
  input  logic                      s_err_i,
  input  logic                      s_rty_i,
  // status
  output logic [3:0]                gnt_o,
  output logic                      timeout_o,
  output logic [1:0]                dbg_state_o
);

  localparam int SW = c_DATA_WIDTH / 8;
  localparam logic       WD_EN    = (TIMEOUT != 0);
  localparam logic [7:0] WD_LIMIT = 8'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_ABORT = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  gnt_q, gnt_d;
  logic [1:0]  last_q, last_d;
  logic [7:0]  wd_cnt_q, wd_cnt_d;
  logic        timeout_q, timeout_d;

  // Master ports gathered into arrays so the mux logic is index-driven.
  logic [3:0]              m_cyc, m_stb, m_we;
  logic [c_DATA_WIDTH-1:0] m_dat [4];
  logic [31:0]             m_adr [4];
  logic [SW-1:0]           m_sel [4];
  logic [2:0]              m_cti [4];
  logic [3:0]              m_ack, m_err, m_rty;
  logic [c_DATA_WIDTH-1:0] m_rdat [4];

  assign m_cyc = {m3_cyc_i, m2_cyc_i, m1_cyc_i, m0_cyc_i};
  assign m_stb = {m3_stb_i, m2_stb_i, m1_stb_i, m0_stb_i};
  assign m_we  = {m3_we_i,  m2_we_i,  m1_we_i,  m0_we_i};
  assign m_dat = '{m0_dat_i, m1_dat_i, m2_dat_i, m3_dat_i};
  assign m_adr = '{m0_adr_i, m1_adr_i, m2_adr_i, m3_adr_i};
  assign m_sel = '{m0_sel_i, m1_sel_i, m2_sel_i, m3_sel_i};
  assign m_cti = '{m0_cti_i, m1_cti_i, m2_cti_i, m3_cti_i};

  assign {m3_ack_o, m2_ack_o, m1_ack_o, m0_ack_o} = m_ack;
  assign {m3_err_o, m2_err_o, m1_err_o, m0_err_o} = m_err;
  assign {m3_rty_o, m2_rty_o, m1_rty_o, m0_rty_o} = m_rty;
  assign m0_dat_o = m_rdat[0];
  assign m1_dat_o = m_rdat[1];
  assign m2_dat_o = m_rdat[2];
  assign m3_dat_o = m_rdat[3];

  assign gnt_o       = gnt_q;
  assign timeout_o   = timeout_q;
  assign dbg_state_o = state_q;

  logic in_grant, in_abort, term, gnt_cyc;
  assign in_grant = (state_q == ST_GRANT);
  assign in_abort = (state_q == ST_ABORT);
  assign term     = s_ack_i | s_err_i | s_rty_i;
  assign gnt_cyc  = |(gnt_q & m_cyc);

  // Request mux towards the slave and response demux back to the masters.
  always_comb begin
    s_dat_o = '0;
    s_adr_o = '0;
    s_sel_o = '0;
    s_cti_o = '0;
    s_we_o  = 1'b0;
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    m_ack   = '0;
    m_err   = '0;
    m_rty   = '0;
    for (int i = 0; i < 4; i++) begin
      m_rdat[i] = '0;
      if (in_grant && gnt_q[i]) begin
        s_dat_o   = m_dat[i];
        s_adr_o   = m_adr[i];
        s_sel_o   = m_sel[i];
        s_cti_o   = m_cti[i];
        s_we_o    = m_we[i];
        s_cyc_o   = m_cyc[i];
        s_stb_o   = m_stb[i];
        m_rdat[i] = s_dat_i;
        m_ack[i]  = s_ack_i;
        m_err[i]  = s_err_i;
        m_rty[i]  = s_rty_i;
      end
      // timeout_q is high only in the first ABORT cycle, giving a 1-cycle err.
      if (in_abort && gnt_q[i] && timeout_q) begin
        m_err[i] = 1'b1;
      end
    end
  end

  // Next-state logic.
  logic       found;
  logic [1:0] idx;

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    last_d    = last_q;
    wd_cnt_d  = '0;
    timeout_d = 1'b0;
    found     = 1'b0;
    idx       = last_q;
    case (state_q)
      ST_IDLE: begin
        // Search order last+1, last+2, last+3, last (2-bit wrap).
        for (int k = 1; k <= 4; k++) begin
          idx = last_q + 2'(k);
          if (!found && m_cyc[idx]) begin
            found   = 1'b1;
            gnt_d   = 4'b0001 << idx;
            last_d  = idx;
            state_d = ST_GRANT;
          end
        end
      end
      ST_GRANT: begin
        if (!gnt_cyc) begin
          state_d = ST_IDLE;
          gnt_d   = '0;
        end else if (s_stb_o && !term) begin
          // A termination in the trip cycle takes the normal path instead.
          if (WD_EN && (wd_cnt_q == WD_LIMIT)) begin
            state_d   = ST_ABORT;
            timeout_d = 1'b1;
          end else begin
            wd_cnt_d = (wd_cnt_q == 8'hff) ? 8'hff : wd_cnt_q + 8'd1;
          end
        end
      end
      ST_ABORT: begin
        if (!gnt_cyc) begin
          state_d = ST_IDLE;
          gnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= ST_IDLE;
      gnt_q     <= '0;
      last_q    <= 2'd3;
      wd_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      last_q    <= last_d;
      wd_cnt_q  <= wd_cnt_d;
      timeout_q <= timeout_d;
    end
  end

endmodule

// File: tb/tb_wb_rr_arb4.sv
// tb_wb_rr_arb4: directed bench for wb_rr_arb4 (TIMEOUT=8).
// Stimulus pushes expected grant/termination events (with the cycle they
// must appear in) into exp_q; a negedge monitor pops and compares each event
// the DUT presents. Point checks cover muxing, reset and abort behaviour.
module tb_wb_rr_arb4;

  localparam int DW = 64;
  localparam int EW = 32;
  localparam logic [1:0] K_GNT = 2'd1;
  localparam logic [1:0] K_RSP = 2'd2;

  // clock / reset
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] cyc_cnt = '0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 16'd1;

  // DUT signals
  logic [3:0]    m_cyc, m_stb, m_we;
  logic [DW-1:0] m_dat_i [4];
  logic [DW-1:0] m_dat_o [4];
  logic [31:0]   m_adr [4];
  logic [7:0]    m_sel [4];
  logic [2:0]    m_cti [4];
  logic [3:0]    m_ack, m_err, m_rty;
  logic [DW-1:0] s_dat_o, s_dat_i;
  logic [31:0]   s_adr_o;
  logic [7:0]    s_sel_o;
  logic [2:0]    s_cti_o;
  logic          s_we_o, s_cyc_o, s_stb_o;
  logic          s_ack_i, s_err_i, s_rty_i;
  logic [3:0]    gnt_o;
  logic          timeout_o;
  logic [1:0]    dbg_state_o;

  wb_rr_arb4 #(.c_DATA_WIDTH(DW), .TIMEOUT(8)) dut (
    .clk(clk), .rstn(rstn),
    .m0_dat_i(m_dat_i[0]), .m0_dat_o(m_dat_o[0]), .m0_adr_i(m_adr[0]), .m0_sel_i(m_sel[0]),
    .m0_cti_i(m_cti[0]), .m0_we_i(m_we[0]), .m0_cyc_i(m_cyc[0]), .m0_stb_i(m_stb[0]),
    .m0_ack_o(m_ack[0]), .m0_err_o(m_err[0]), .m0_rty_o(m_rty[0]),
    .m1_dat_i(m_dat_i[1]), .m1_dat_o(m_dat_o[1]), .m1_adr_i(m_adr[1]), .m1_sel_i(m_sel[1]),
    .m1_cti_i(m_cti[1]), .m1_we_i(m_we[1]), .m1_cyc_i(m_cyc[1]), .m1_stb_i(m_stb[1]),
    .m1_ack_o(m_ack[1]), .m1_err_o(m_err[1]), .m1_rty_o(m_rty[1]),
    .m2_dat_i(m_dat_i[2]), .m2_dat_o(m_dat_o[2]), .m2_adr_i(m_adr[2]), .m2_sel_i(m_sel[2]),
    .m2_cti_i(m_cti[2]), .m2_we_i(m_we[2]), .m2_cyc_i(m_cyc[2]), .m2_stb_i(m_stb[2]),
    .m2_ack_o(m_ack[2]), .m2_err_o(m_err[2]), .m2_rty_o(m_rty[2]),
    .m3_dat_i(m_dat_i[3]), .m3_dat_o(m_dat_o[3]), .m3_adr_i(m_adr[3]), .m3_sel_i(m_sel[3]),
    .m3_cti_i(m_cti[3]), .m3_we_i(m_we[3]), .m3_cyc_i(m_cyc[3]), .m3_stb_i(m_stb[3]),
    .m3_ack_o(m_ack[3]), .m3_err_o(m_err[3]), .m3_rty_o(m_rty[3]),
    .s_dat_o(s_dat_o), .s_adr_o(s_adr_o), .s_sel_o(s_sel_o), .s_cti_o(s_cti_o),
    .s_we_o(s_we_o), .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i),
    .gnt_o(gnt_o), .timeout_o(timeout_o), .dbg_state_o(dbg_state_o)
  );

  // scoreboard: {kind[1:0], cycle[15:0], 1'b0, payload[12:0]}
  logic [EW-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  logic [15:0] t0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_cnt);
    end
  endtask

  task automatic push_gnt(input int off, input logic [3:0] g);
    exp_q.push_back({K_GNT, 16'(t0 + 16'(off)), 1'b0, 9'b0, g});
  endtask

  // rsp payload: {timeout, err[3:0], ack[3:0], rty[3:0]}
  task automatic push_rsp(input int off, input logic to, input logic [3:0] err,
                          input logic [3:0] ack);
    exp_q.push_back({K_RSP, 16'(t0 + 16'(off)), 1'b0, to, err, ack, 4'b0});
  endtask

  task automatic sb_check(input logic [EW-1:0] act);
    logic [EW-1:0] exp;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL sb_unexpected: got %0h expected no event", act);
    end else begin
      exp = exp_q.pop_front();
      if (act !== exp) begin
        errors++;
        $display("FAIL sb_event: got %0h expected %0h", act, exp);
      end
    end
  endtask

  // monitor: new grants and any termination/timeout are events
  logic [3:0] prev_g = '0;
  always @(negedge clk) begin
    logic [12:0] rsp;
    rsp = {timeout_o, m_err, m_ack, m_rty};
    if (gnt_o != prev_g && gnt_o != 4'b0) sb_check({K_GNT, cyc_cnt, 1'b0, 9'b0, gnt_o});
    prev_g = gnt_o;
    if (rsp != 13'b0) sb_check({K_RSP, cyc_cnt, 1'b0, rsp});
  end

  // driver
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    m_cyc = '0; m_stb = '0; m_we = '0;
    for (int i = 0; i < 4; i++) begin
      m_dat_i[i] = {32'hDA7A_0000, 32'(i)};
      m_adr[i]   = 32'h1000_0000 + 32'(i) * 32'h10;
      m_sel[i]   = 8'hff;
      m_cti[i]   = 3'b000;
    end
    s_dat_i = 64'hCAFE_F00D_0000_0001;
    s_ack_i = 1'b0; s_err_i = 1'b0; s_rty_i = 1'b0;
    rstn = 1'b0;
    repeat (3) tick();

    // reset state
    check("rst_gnt", gnt_o, 4'b0);
    check("rst_s_cyc", s_cyc_o, 1'b0);
    check("rst_s_stb", s_stb_o, 1'b0);
    check("rst_timeout", timeout_o, 1'b0);
    check("rst_ack", m_ack, 4'b0);
    check("rst_err", m_err, 4'b0);
    check("rst_dat_o1", m_dat_o[1], 64'h0);
    check("rst_state", dbg_state_o, 2'd0);
    rstn = 1'b1;
    tick(); tick();

    // all four request: order m0,m1,m2,m3,m0, 4-cycle holds, 2-cycle gaps
    t0 = cyc_cnt;
    for (int p = 0; p < 5; p++) push_gnt(1 + 6 * p, 4'b0001 << (p % 4));
    for (int c = 0; c < 31; c++) begin
      m_cyc[0] = (c < 29) && (c != 5);
      m_cyc[1] = (c < 11);
      m_cyc[2] = (c < 17);
      m_cyc[3] = (c < 23);
      m_stb = m_cyc;
      #1;
      if (c == 5 || c == 6) check("rr_gap_s_cyc", s_cyc_o, 1'b0);
      if (c == 7) check("rr_m1_s_cyc", s_cyc_o, 1'b1);
      tick();
    end

    // single request from m1, slave acks in cycle 3
    t0 = cyc_cnt;
    push_gnt(1, 4'b0010);
    push_rsp(3, 1'b0, 4'b0, 4'b0010);
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_we[1] = 1'b1;
    tick();
    #1;
    check("single_gnt", gnt_o, 4'b0010);
    check("single_s_cyc", s_cyc_o, 1'b1);
    check("single_s_adr", s_adr_o, 32'h1000_0010);
    check("single_s_we", s_we_o, 1'b1);
    check("single_s_dat", s_dat_o, 64'hDA7A_0000_0000_0001);
    tick();
    tick();
    s_ack_i = 1'b1;
    #1;
    check("single_m1_dat", m_dat_o[1], 64'hCAFE_F00D_0000_0001);
    check("single_m0_dat", m_dat_o[0], 64'h0);
    tick();
    s_ack_i = 1'b0; m_cyc[1] = 1'b0; m_stb[1] = 1'b0; m_we[1] = 1'b0;
    tick(); tick();

    // burst on m2 while m0 waits
    t0 = cyc_cnt;
    push_gnt(1, 4'b0100);
    for (int b = 1; b <= 4; b++) push_rsp(b, 1'b0, 4'b0, 4'b0100);
    push_gnt(7, 4'b0001);
    push_rsp(8, 1'b0, 4'b0, 4'b0001);
    m_cti[2] = 3'b010;
    m_cyc[2] = 1'b1; m_stb[2] = 1'b1;
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
    for (int b = 1; b <= 4; b++) begin
      tick();
      s_ack_i = 1'b1;
      m_cti[2] = (b == 4) ? 3'b111 : 3'b010;
      #1;
      check("burst_s_cti", s_cti_o, (b == 4) ? 3'b111 : 3'b010);
      check("burst_gnt", gnt_o, 4'b0100);
    end
    tick();
    s_ack_i = 1'b0; m_cyc[2] = 1'b0; m_stb[2] = 1'b0; m_cti[2] = 3'b000;
    #1;
    check("burst_hold_gnt", gnt_o, 4'b0100);
    check("burst_drop_s_cyc", s_cyc_o, 1'b0);
    tick();
    check("burst_idle_gnt", gnt_o, 4'b0);
    tick();
    tick();
    s_ack_i = 1'b1;
    tick();
    s_ack_i = 1'b0; m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
    tick(); tick();

    // watchdog: m3 never acked, err/timeout 8 cycles after first granted stb
    t0 = cyc_cnt;
    push_gnt(1, 4'b1000);
    push_rsp(9, 1'b1, 4'b1000, 4'b0);
    m_cyc[3] = 1'b1; m_stb[3] = 1'b1;
    repeat (9) tick();
    #1;
    check("wd_abort_s_cyc", s_cyc_o, 1'b0);
    check("wd_abort_state", dbg_state_o, 2'd2);
    tick();
    #1;
    check("wd_abort2_s_cyc", s_cyc_o, 1'b0);
    check("wd_err_one_cycle", m_err[3], 1'b0);
    check("wd_timeout_one_cycle", timeout_o, 1'b0);
    tick();
    check("wd_hold_gnt", gnt_o, 4'b1000);
    tick();
    m_cyc[3] = 1'b0; m_stb[3] = 1'b0;
    tick();
    check("wd_release_gnt", gnt_o, 4'b0);
    tick();

    // race: ack lands in the trip cycle, the ack wins
    t0 = cyc_cnt;
    push_gnt(1, 4'b1000);
    push_rsp(8, 1'b0, 4'b0, 4'b1000);
    m_cyc[3] = 1'b1; m_stb[3] = 1'b1;
    repeat (8) tick();
    s_ack_i = 1'b1;
    #1;
    check("race_no_err", m_err[3], 1'b0);
    tick();
    s_ack_i = 1'b0; m_cyc[3] = 1'b0; m_stb[3] = 1'b0;
    #1;
    check("race_state_grant", dbg_state_o, 2'd1);
    check("race_no_timeout", timeout_o, 1'b0);
    tick(); tick();

    // reset in the middle of m2's grant
    t0 = cyc_cnt;
    push_gnt(1, 4'b0100);
    m_cyc[2] = 1'b1; m_stb[2] = 1'b1;
    tick(); tick();
    check("mid_gnt_before", gnt_o, 4'b0100);
    rstn = 1'b0;
    #1;
    check("mid_rst_gnt", gnt_o, 4'b0);
    check("mid_rst_s_cyc", s_cyc_o, 1'b0);
    check("mid_rst_s_stb", s_stb_o, 1'b0);
    tick();
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
    rstn = 1'b1;
    push_gnt(4, 4'b0001);
    tick();
    #1;
    check("post_rst_gnt", gnt_o, 4'b0001);
    check("post_rst_s_adr", s_adr_o, 32'h1000_0000);
    m_cyc = '0; m_stb = '0;
    repeat (3) tick();

    check("sb_drain", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
